mandel_render: RTL and testbench

- Upstream producer for the VGA output stage (640x400 visible, 25 MHz `clock` domain).
- Sweeps every visible pixel and runs the Mandelbrot iteration z <- z^2 + c in signed fixed point.
- Writes one 8-bit iteration count per pixel into the framebuffer write port.
- The video stage later reads the framebuffer and maps the counts to 4:4:4 RGB.

---
 rtl/mandel_render_if.sv | 24 ++
 rtl/mandel_render.sv | 172 +++++++++++++++++
 tb/tb_mandel_render.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_render_if.sv
// Framebuffer write port between the Mandelbrot renderer and the framebuffer.
// The master holds addr/data stable while we is high until ready is seen.
interface mandel_render_if #(
    parameter int AW = 18
);
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          ready;

    modport master (
        output we,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  we,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/mandel_render.sv
// Mandelbrot renderer: one 8-bit escape count per pixel into the framebuffer.
// Define MANDEL_STATS_EN to add the iter_total iteration counter port.
module mandel_render #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 400,
    parameter int MAX_ITER = 255,
    parameter int AW       = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] step,
    output logic        busy,
    output logic        done,
`ifdef MANDEL_STATS_EN
    output logic [31:0] iter_total,
`endif
    mandel_render_if.master fb
);
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ITER,
        WRITE,
        FIN
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = 1;

    state_t state, next;

    logic [31:0]   x0_q, step_q;
    logic [31:0]   cr, ci, zx, zy;
    logic [7:0]    iter;
    logic [15:0]   px, py;
    logic [AW-1:0] addr_q;
    logic [7:0]    data_q;

    logic [31:0] ax, ay, xx, yy, xy_mag, xy;
    logic [63:0] sq_x, sq_y, sq_xy;
    logic [32:0] mag_sum;
    logic        esc, at_max, last_col, last_row;
    logic        unused_bits;

    always_comb begin
        ax       = zx[31] ? -zx : zx;
        ay       = zy[31] ? -zy : zy;
        sq_x     = {32'd0, ax} * {32'd0, ax};
        sq_y     = {32'd0, ay} * {32'd0, ay};
        sq_xy    = {32'd0, ax} * {32'd0, ay};
        xx       = {1'b0, sq_x[58:28]};
        yy       = {1'b0, sq_y[58:28]};
        xy_mag   = {1'b0, sq_xy[58:28]};
        xy       = (zx[31] ^ zy[31]) ? -xy_mag : xy_mag;
        mag_sum  = {1'b0, xx} + {1'b0, yy};
        // Magnitudes >= 2.0 escape before the squares can overflow
        esc      = (|ax[31:29]) || (|ay[31:29])
                || (mag_sum >= 33'h0_4000_0000);
        at_max   = (iter == 8'(MAX_ITER));
        last_col = (px == 16'(WIDTH - 1));
        last_row = (py == 16'(HEIGHT - 1));
    end

    assign unused_bits = ^{sq_x[63:59], sq_x[27:0],
                           sq_y[63:59], sq_y[27:0],
                           sq_xy[63:59], sq_xy[27:0]};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (start) next = INIT;
            INIT:  next = ITER;
            ITER:  if (esc || at_max) next = WRITE;
            WRITE: begin
                if (fb.ready)
                    next = (last_col && last_row) ? FIN : INIT;
            end
            FIN:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign busy    = (state == INIT) || (state == ITER)
                  || (state == WRITE);
    assign done    = (state == FIN);
    assign fb.we   = (state == WRITE);
    assign fb.addr = addr_q;
    assign fb.data = data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            x0_q   <= '0;
            step_q <= '0;
            cr     <= '0;
            ci     <= '0;
            zx     <= '0;
            zy     <= '0;
            iter   <= '0;
            px     <= '0;
            py     <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x0_q   <= x0;
                        step_q <= step;
                        cr     <= x0;
                        ci     <= y0;
                        px     <= '0;
                        py     <= '0;
                        addr_q <= '0;
                    end
                end
                INIT: begin
                    zx   <= '0;
                    zy   <= '0;
                    iter <= '0;
                end
                ITER: begin
                    if (esc) begin
                        data_q <= iter;
                    end else if (at_max) begin
                        data_q <= '0;
                    end else begin
                        zx   <= xx - yy + cr;
                        zy   <= (xy << 1) + ci;
                        iter <= iter + 8'd1;
                    end
                end
                WRITE: begin
                    if (fb.ready) begin
                        if (last_col) begin
                            px <= '0;
                            cr <= x0_q;
                            py <= py + 16'd1;
                            ci <= ci + step_q;
                        end else begin
                            px <= px + 16'd1;
                            cr <= cr + step_q;
                        end
                        // Hold the final address so it never leaves the frame
                        if (!(last_col && last_row))
                            addr_q <= addr_q + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MANDEL_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            iter_total <= '0;
        end else if (state == IDLE && start) begin
            iter_total <= '0;
        end else if (state == ITER && !esc && !at_max) begin
            if (iter_total != 32'hFFFF_FFFF)
                iter_total <= iter_total + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mandel_render.sv
// Directed and randomized bench for mandel_render on a small 4x2 frame.
// Expected counts come from a plain-integer escape-time model.
module tb_mandel_render;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int MAXI = 255;
    localparam int AW   = 18;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x0, y0, step;
    logic        busy, done;
`ifdef MANDEL_STATS_EN
    logic [31:0] iter_total;
`endif

    mandel_render_if #(.AW(AW)) fb ();

    mandel_render #(
        .WIDTH(W),
        .HEIGHT(H),
        .MAX_ITER(MAXI),
        .AW(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .x0(x0),
        .y0(y0),
        .step(step),
        .busy(busy),
        .done(done),
`ifdef MANDEL_STATS_EN
        .iter_total(iter_total),
`endif
        .fb(fb)
    );

    always #5 clock = ~clock;

    typedef struct {
        int     addr;
        int     data;
        longint cyc;
    } wr_t;

    wr_t    wq[$];
    longint cyc = 0;
    int     done_cnt = 0;
    int     compared = 0;
    int     mismatched = 0;
    longint exp_total;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (fb.we && fb.ready)
            wq.push_back('{int'(fb.addr), int'(fb.data), cyc});
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input longint obs,
                       input longint exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Escape-time count from the fixed-point rules, using 64-bit integers
    function automatic int ref_iter(input logic [31:0] cr,
                                    input logic [31:0] ci);
        logic [31:0] zx = '0;
        logic [31:0] zy = '0;
        longint ax, ay, xx, yy, xy;
        for (int it = 0; it <= MAXI; it++) begin
            ax = longint'($signed(zx));
            ay = longint'($signed(zy));
            if (ax < 0) ax = -ax;
            if (ay < 0) ay = -ay;
            if (ax >= 64'h2000_0000 || ay >= 64'h2000_0000)
                return it;
            xx = (ax * ax) >>> 28;
            yy = (ay * ay) >>> 28;
            if (xx + yy >= 64'h4000_0000) return it;
            if (it == MAXI) return 0;
            xy = (ax * ay) >>> 28;
            if (zx[31] ^ zy[31]) xy = -xy;
            zx = 32'(xx - yy + longint'($signed(cr)));
            zy = 32'(2 * xy + longint'($signed(ci)));
        end
        return 0;
    endfunction

    task automatic run_frame(input logic [31:0] xv,
                             input logic [31:0] yv,
                             input logic [31:0] sv);
        bit seen = 0;
        wq.delete();
        done_cnt = 0;
        @(posedge clock); #1;
        x0 = xv; y0 = yv; step = sv; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("frame_done_seen", longint'(seen), 1);
        @(negedge clock);
        chk("busy_after_done", longint'(busy), 0);
        repeat (3) @(negedge clock);
        chk("done_pulses", done_cnt, 1);
    endtask

    task automatic check_frame(input logic [31:0] xv,
                               input logic [31:0] yv,
                               input logic [31:0] sv);
        int r;
        logic [31:0] cr, ci;
        exp_total = 0;
        chk("write_count", wq.size(), W * H);
        for (int i = 0; i < wq.size() && i < W * H; i++) begin
            cr = xv + 32'(i % W) * sv;
            ci = yv + 32'(i / W) * sv;
            r  = ref_iter(cr, ci);
            exp_total += (r == 0) ? MAXI : r;
            chk($sformatf("addr[%0d]", i), wq[i].addr, i);
            chk($sformatf("data[%0d]", i), wq[i].data, r);
        end
    endtask

    initial begin
        bit seen;
        int sx, sy;
        reset = 1'b1;
        start = 1'b0;
        x0 = '0; y0 = '0; step = '0;
        fb.ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", fb.we, 0);
        chk("rst_addr", fb.addr, 0);
        chk("rst_data", fb.data, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // c = 0 never escapes: every pixel runs to the cap
        run_frame(32'h0, 32'h0, 32'h0);
        check_frame(32'h0, 32'h0, 32'h0);
        for (int i = 1; i < wq.size(); i++)
            chk($sformatf("pixel_gap[%0d]", i),
                wq[i].cyc - wq[i-1].cyc, MAXI + 3);
`ifdef MANDEL_STATS_EN
        chk("iter_total_c0", iter_total, 8 * MAXI);
`endif

        run_frame(32'h2800_0000, 32'h0, 32'h0);
        check_frame(32'h2800_0000, 32'h0, 32'h0);
        chk("data_2p5", wq[0].data, 1);
        run_frame(32'hE000_0000, 32'h0, 32'h0);
        check_frame(32'hE000_0000, 32'h0, 32'h0);
        chk("data_m2", wq[0].data, 1);
        run_frame(32'hF000_0000, 32'h0, 32'h0);
        check_frame(32'hF000_0000, 32'h0, 32'h0);
        chk("data_m1", wq[0].data, 0);

        for (int n = 0; n < 5; n++) begin
            sx = -536870912 + int'($urandom_range(0, 700000000));
            sy = -322122547 + int'($urandom_range(0, 644245094));
            step = $urandom_range(0, 32'h0100_0000);
            x0 = sx;
            y0 = sy;
            run_frame(x0, y0, step);
            check_frame(x0, y0, step);
`ifdef MANDEL_STATS_EN
            chk($sformatf("iter_total_rnd%0d", n),
                iter_total, exp_total);
`endif
        end

        // Backpressure on the first write, then reset mid-frame
        wq.delete();
        done_cnt = 0;
        fb.ready = 1'b0;
        @(posedge clock); #1;
        x0 = 32'h2800_0000; y0 = '0; step = '0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (fb.we) begin
                seen = 1;
                break;
            end
        end
        chk("stall_we_seen", longint'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_we", fb.we, 1);
            chk("stall_addr", fb.addr, 0);
            chk("stall_data", fb.data, 1);
            chk("stall_no_write", wq.size(), 0);
            @(negedge clock);
        end
        @(posedge clock); #1;
        fb.ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (wq.size() >= 1) begin
                seen = 1;
                break;
            end
        end
        chk("stall_release", longint'(seen), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_busy", busy, 0);
        chk("midrst_we", fb.we, 0);
        chk("midrst_addr", fb.addr, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("midrst_writes", wq.size(), 1);
        chk("midrst_no_done", done_cnt, 0);
`ifdef MANDEL_STATS_EN
        chk("midrst_iter_total", iter_total, 0);
`endif

        x0 = 32'hFC00_0000;
        y0 = 32'h0200_0000;
        step = 32'h0080_0000;
        run_frame(x0, y0, step);
        check_frame(x0, y0, step);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
